// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the EX/MEM data-memory sequencer: mem_op fields,
// size codes, state encoding, byte-enable patterns and the alignment rule.
package mem_bus_ctrl_pkg;

   localparam int OP_VALID_BIT = 3;
   localparam int OP_UNS_BIT   = 2;
   localparam int TIMEOUT_DEF  = 255;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } mem_size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_RESP = 2'b10,
      ST_DONE = 2'b11
   } ctrl_state_e;

   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

   function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] addr_lo);
      logic mis;
      case (size)
         SZ_HALF: mis = addr_lo[0];
         SZ_WORD: mis = (addr_lo != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Data-bus request/response bundle between the memory sequencer (master)
// and the data memory or interconnect (slave).
interface mem_bus_ctrl_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  bus_req_out;
   logic                  bus_we_out;
   logic [ADDR_WIDTH-1:0] bus_addr_out;
   logic [3:0]            bus_be_out;
   logic [DATA_WIDTH-1:0] bus_wdata_out;
   logic                  bus_gnt_in;
   logic                  bus_rvalid_in;
   logic [DATA_WIDTH-1:0] bus_rdata_in;
   logic                  bus_err_in;

   modport master (
      output bus_req_out, bus_we_out, bus_addr_out, bus_be_out, bus_wdata_out,
      input  bus_gnt_in, bus_rvalid_in, bus_rdata_in, bus_err_in
   );

   modport slave (
      input  bus_req_out, bus_we_out, bus_addr_out, bus_be_out, bus_wdata_out,
      output bus_gnt_in, bus_rvalid_in, bus_rdata_in, bus_err_in
   );
endinterface

// File: rtl/mem_bus_ctrl_lane_align.sv
// Combinational byte-lane logic: store byte enables and replication,
// load lane selection with sign/zero extension, and the misalignment flag.
module mem_lane_align
   import mem_bus_ctrl_pkg::*;
(
   input  mem_size_e   size_i,
   input  logic        uns_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] ldata_o,
   output logic        misalign_o
);
   logic [7:0]  byte_s;
   logic [15:0] half_s;

   assign byte_s     = rdata_i[{addr_lo_i, 3'b000} +: 8];
   assign half_s     = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
   assign misalign_o = is_misaligned(size_i, addr_lo_i);

   // Lane steering per access size; the reserved size drives nothing onto the bus
   always_comb begin
      be_o    = 4'b0000;
      wdata_o = 32'h0000_0000;
      ldata_o = 32'h0000_0000;
      case (size_i)
         SZ_BYTE: begin
            be_o    = BE_BYTE << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
            ldata_o = {{24{byte_s[7] & ~uns_i}}, byte_s};
         end
         SZ_HALF: begin
            be_o    = BE_HALF << addr_lo_i;
            wdata_o = {2{wdata_i[15:0]}};
            ldata_o = {{16{half_s[15] & ~uns_i}}, half_s};
         end
         SZ_WORD: begin
            be_o    = BE_WORD;
            wdata_o = wdata_i;
            ldata_o = rdata_i;
         end
         default: begin
            be_o    = 4'b0000;
            wdata_o = 32'h0000_0000;
            ldata_o = 32'h0000_0000;
         end
      endcase
   end
endmodule

// File: rtl/mem_bus_ctrl.sv
// Sequences the EX/MEM data access onto the req/gnt/rvalid bus, stalls the
// pipeline until it completes and returns extended load data or a fault pulse.
module mem_bus_ctrl
   import mem_bus_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = TIMEOUT_DEF
) (
   input  logic                  clk_in,
   input  logic                  reset_in,
   input  logic [ADDR_WIDTH-1:0] mem_addr_in,
   input  logic [DATA_WIDTH-1:0] mem_data_in,
   input  logic                  mem_we_in,
   input  logic [3:0]            mem_op_in,
   mem_bus_ctrl_if.master        bus,
   output logic                  stall_req_out,
   output logic [DATA_WIDTH-1:0] load_data_out,
   output logic                  load_valid_out,
   output logic                  fault_out
);
   localparam logic [7:0] TMO_CNT = 8'(TIMEOUT);

   ctrl_state_e           state_q;
   logic [7:0]            cnt_q;
   logic [1:0]            addr_lo_q;
   mem_size_e             size_q;
   logic                  uns_q;
   logic                  bus_req_q;
   logic                  bus_we_q;
   logic [ADDR_WIDTH-1:0] bus_addr_q;
   logic [3:0]            bus_be_q;
   logic [DATA_WIDTH-1:0] bus_wdata_q;
   logic [DATA_WIDTH-1:0] load_data_q;
   logic                  load_valid_q;
   logic                  fault_q;

   mem_size_e             sel_size_s;
   logic                  sel_uns_s;
   logic [1:0]            sel_addr_lo_s;
   logic [3:0]            be_s;
   logic [DATA_WIDTH-1:0] wdata_s;
   logic [DATA_WIDTH-1:0] ldata_s;
   logic                  misalign_s;
   logic                  access_bad_s;

   // IDLE decodes the live access; later states extract load data from the latched copy
   always_comb begin
      if (state_q == ST_IDLE) begin
         sel_size_s    = mem_size_e'(mem_op_in[1:0]);
         sel_uns_s     = mem_op_in[OP_UNS_BIT];
         sel_addr_lo_s = mem_addr_in[1:0];
      end else begin
         sel_size_s    = size_q;
         sel_uns_s     = uns_q;
         sel_addr_lo_s = addr_lo_q;
      end
   end

   assign access_bad_s = misalign_s | (sel_size_s == SZ_RSVD);

   mem_lane_align u_lane_align (
      .size_i     (sel_size_s),
      .uns_i      (sel_uns_s),
      .addr_lo_i  (sel_addr_lo_s),
      .wdata_i    (mem_data_in),
      .rdata_i    (bus.bus_rdata_in),
      .be_o       (be_s),
      .wdata_o    (wdata_s),
      .ldata_o    (ldata_s),
      .misalign_o (misalign_s)
   );

   // Sequencer state, wait counter and all registered outputs; handshakes beat the timeout
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 8'd0;
         addr_lo_q    <= 2'b00;
         size_q       <= SZ_BYTE;
         uns_q        <= 1'b0;
         bus_req_q    <= 1'b0;
         bus_we_q     <= 1'b0;
         bus_addr_q   <= '0;
         bus_be_q     <= 4'b0000;
         bus_wdata_q  <= '0;
         load_data_q  <= '0;
         load_valid_q <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         load_valid_q <= 1'b0;
         fault_q      <= 1'b0;
         load_data_q  <= '0;
         case (state_q)
            ST_IDLE: begin
               if (mem_op_in[OP_VALID_BIT]) begin
                  addr_lo_q <= mem_addr_in[1:0];
                  size_q    <= sel_size_s;
                  uns_q     <= mem_op_in[OP_UNS_BIT];
                  if (access_bad_s) begin
                     fault_q <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     cnt_q       <= 8'd0;
                     bus_req_q   <= 1'b1;
                     bus_we_q    <= mem_we_in;
                     bus_addr_q  <= {mem_addr_in[ADDR_WIDTH-1:2], 2'b00};
                     bus_be_q    <= be_s;
                     bus_wdata_q <= wdata_s;
                     state_q     <= ST_REQ;
                  end
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_REQ: begin
               if (bus.bus_gnt_in) begin
                  bus_req_q <= 1'b0;
                  state_q   <= bus_we_q ? ST_DONE : ST_RESP;
               end else if (cnt_q == TMO_CNT) begin
                  bus_req_q <= 1'b0;
                  fault_q   <= 1'b1;
                  state_q   <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            ST_RESP: begin
               if (bus.bus_rvalid_in) begin
                  state_q <= ST_DONE;
                  if (bus.bus_err_in) begin
                     fault_q <= 1'b1;
                  end else begin
                     load_valid_q <= 1'b1;
                     load_data_q  <= ldata_s;
                  end
               end else if (cnt_q == TMO_CNT) begin
                  fault_q <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Gated by reset so the stall also drops the instant reset asserts
   assign stall_req_out = reset_in &
                          (((state_q == ST_IDLE) & mem_op_in[OP_VALID_BIT]) |
                           (state_q == ST_REQ) | (state_q == ST_RESP));

   assign bus.bus_req_out   = bus_req_q;
   assign bus.bus_we_out    = bus_we_q;
   assign bus.bus_addr_out  = bus_addr_q;
   assign bus.bus_be_out    = bus_be_q;
   assign bus.bus_wdata_out = bus_wdata_q;
   assign load_data_out     = load_data_q;
   assign load_valid_out    = load_valid_q;
   assign fault_out         = fault_q;
endmodule
